// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the uart_tx round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set req bit above last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the closest candidate is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers with round-robin grants.
// Latency: ack one edge after req is sampled in IDLE, start one edge after ack.
// Backpressure: grants held off while busy or while tx_active is high.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          start,
    output logic [DATA_WIDTH-1:0]         tx_data_in,
    input  logic                          tx_active,
    input  logic                          done_tx,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          timeout_err,
    input  logic                          clear_err
);

    localparam int IDX_W    = idx_width(NUM_REQ);
    localparam int CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam int GAP_W    = cnt_width(GAP_CYCLES + 1);
    localparam int GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    start_q, start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wd_cnt_d     = wd_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        ack_d        = '0;
        done_d       = '0;
        start_d      = 1'b0;
        tx_data_d    = tx_data_q;
        // A watchdog expiry later in this cycle overrides the clear.
        err_d        = clear_err ? 1'b0 : err_q;

        case (state_q)
            IDLE: begin
                if (grant_valid && !tx_active) begin
                    ack_d[grant_idx] = 1'b1;
                    owner_d          = grant_idx;
                    last_grant_d     = grant_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_idx == IDX_W'(i)) begin
                            tx_data_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                start_d  = 1'b1;
                wd_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_tx) begin
                    done_d[owner_q] = 1'b1;
                    gap_cnt_d       = '0;
                    state_d         = GAP;
                end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d           = 1'b1;
                    done_d[owner_q] = 1'b1;
                    gap_cnt_d       = '0;
                    state_d         = GAP;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                // GAP always lasts at least one cycle, even with GAP_CYCLES=0.
                if (gap_cnt_q >= GAP_W'(GAP_LAST)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            wd_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            start_q      <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wd_cnt_q     <= wd_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            start_q      <= start_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign start       = start_q;
    assign tx_data_in  = tx_data_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = err_q;

endmodule
